quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: position counter width.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per input channel, minimum 2.
REQ-003 The block SHALL have parameter FILT_LEN, default 3: consecutive stable samples required to accept a new input level, minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports a and b, input, 1 bit each: asynchronous quadrature phase inputs.
REQ-007 The block SHALL have port en, input, 1 bit: count enable; when low, transitions are tracked but not counted.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of count and err_flag.
REQ-009 The block SHALL have port count, output, CNT_W bits: signed-agnostic position, modulo 2^CNT_W.
REQ-010 The block SHALL have port up_down, output, 1 bit: last valid direction (1 = up, 0 = down).
REQ-011 The block SHALL have port step, output, 1 bit: one-cycle pulse per valid counted transition.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal transition.
REQ-013 The block SHALL have port err_flag, output, 1 bit: sticky error, held until clr or rst.

Function
REQ-014 Each of a and b SHALL pass through SYNC_STAGES flops and then a glitch filter.
REQ-015 The filtered level SHALL update only after the synchronized level differs from it for FILT_LEN consecutive cycles; any reversion restarts the run count.
REQ-016 The phase state SHALL be {a_f,b_f}; the up sequence is 00->01->11->10->00 and the down sequence is the reverse.
REQ-017 A one-step forward change SHALL, on the next edge: count+1, up_down=1, step=1 (when en=1).
REQ-018 A one-step reverse change SHALL, on the next edge: count-1, up_down=0, step=1 (when en=1).
REQ-019 A two-bit change (00<->11, 01<->10) SHALL produce err=1 and set err_flag, with count, up_down and step unchanged.
REQ-020 With en=0, valid transitions SHALL update the phase state and up_down but leave count unchanged with step=0; errors SHALL still be flagged.
REQ-021 count SHALL wrap: max+1 -> 0 and 0-1 -> max, with no saturation and no flag.
REQ-022 clr=1 SHALL set count=0 and err_flag=0 on the next edge, taking priority over a simultaneous step or error; step and err still pulse.
REQ-023 Latency from a setup-met input edge to step/count SHALL be SYNC_STAGES+FILT_LEN+1 cycles (6 at defaults).
REQ-024 The first filtered sample after reset SHALL initialize the phase state without generating step or err.
REQ-025 At most one transition SHALL be counted per cycle.

Reset
REQ-026 rst=1 SHALL, at the clock edge, set count=0, up_down=0, step=0, err=0 and err_flag=0, clear the synchronizers, the filter run counts and the phase state, and arm the init flag.
REQ-027 rst asserted mid-operation SHALL discard any in-flight filtered transition; rst SHALL take priority over clr and en.

Structure
REQ-028 A shared package quad_pkg SHALL hold the phase-state encoding constants and the direction encoding (UP=1, DOWN=0).
REQ-029 The block SHALL contain one sub-module, quad_filter (synchronizer plus glitch filter, parameterized by SYNC_STAGES and FILT_LEN), instantiated once per channel.

Verification
REQ-030 The bench SHALL hold a,b through reset, then drive 00->01->11->10->00 with 10-cycle holds; required: 4 step pulses, count=4, up_down=1.
REQ-031 The bench SHALL drive the reverse sequence from count=0; required: count=252 (0xFC), up_down=0, no err.
REQ-032 The bench SHALL apply a 2-cycle glitch on a (FILT_LEN=3); required: no step, no err, count unchanged.
REQ-033 The bench SHALL apply 00->11 held 10 cycles; required: err pulses once, err_flag=1, count unchanged; a subsequent clr clears err_flag and count to 0.
REQ-034 The bench SHALL release reset with ab=11; required: no step or err. It SHALL then apply a valid step with en=0; required: count unchanged and up_down updated.
REQ-035 The bench SHALL preload count=255 via up steps and apply one more up step; required: count=0. It SHALL assert rst mid-filter; required: all outputs 0 on the next edge.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg -- shared definitions for the quadrature decoder.
//   phase_t   : {a,b} phase-state encoding, Gray-ordered for the up sequence
//   UP / DOWN : direction encoding reported on up_down
//   phase_fwd / phase_rev : neighbouring phase in the up / down direction
package quad_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Up sequence: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t phase_fwd(input phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  // Down sequence is the reverse: 00 -> 10 -> 11 -> 01 -> 00
  function automatic phase_t phase_rev(input phase_t ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// quad_filter -- synchronizer chain plus glitch filter for one quadrature channel.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   din  : asynchronous raw input
//   dout : filtered level; follows din only after it has differed for FILT_LEN
//          consecutive synchronized samples
//   vld  : high once the filtered level has been seeded after reset
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic vld
);

  localparam int RUN_W   = (FILT_LEN    < 2) ? 1 : $clog2(FILT_LEN + 1);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;
  logic                   filt_p1;
  logic                   vld_p1;
  logic [RUN_W-1:0]       run_cnt;
  logic [PRIME_W-1:0]     prime_cnt;

  assign sync_out = sync_p0[SYNC_STAGES-1];
  assign dout     = filt_p1;
  assign vld      = vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= '0;
      filt_p1   <= 1'b0;
      vld_p1    <= 1'b0;
      run_cnt   <= '0;
      prime_cnt <= '0;
    end else begin
      // stage p0: metastability synchronizer
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};

      // stage p1: glitch filter
      if (!vld_p1) begin
        // After reset the filtered level is seeded straight from the synchronizer
        // once the chain holds real samples, so a non-zero input level at reset
        // release never looks like a transition from 00.
        run_cnt <= '0;
        if (prime_cnt == PRIME_W'(SYNC_STAGES)) begin
          filt_p1 <= sync_out;
          vld_p1  <= 1'b1;
        end else begin
          prime_cnt <= prime_cnt + PRIME_W'(1);
        end
      end else if (sync_out != filt_p1) begin
        if (run_cnt == RUN_W'(FILT_LEN - 1)) begin
          filt_p1 <= sync_out;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + RUN_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder -- quadrature encoder decoder with filtered inputs and position count.
//   clk      : clock (rising edge)
//   rst      : synchronous active-high reset
//   a, b     : asynchronous quadrature phase inputs
//   en       : count enable (transitions still tracked when low)
//   clr      : synchronous clear of count and err_flag
//   count    : position, modulo 2^CNT_W
//   up_down  : last valid direction (1 = up)
//   step     : one-cycle pulse per counted transition
//   err      : one-cycle pulse on an illegal (two-bit) transition
//   err_flag : sticky error until clr or rst
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             err,
  output logic             err_flag
);

  logic   a_f, b_f;
  logic   a_vld, b_vld;
  phase_t cur_ph;
  phase_t phase_p2;
  logic   init_p2;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (a),
    .dout (a_f),
    .vld  (a_vld)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (b),
    .dout (b_f),
    .vld  (b_vld)
  );

  assign cur_ph = phase_t'({a_f, b_f});

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      up_down  <= DOWN;
      step     <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      phase_p2 <= PH_00;
      init_p2  <= 1'b1;
    end else begin
      // stage p2: phase comparison and counting
      step <= 1'b0;
      err  <= 1'b0;
      if (init_p2) begin
        // First seeded sample only establishes the reference phase.
        if (a_vld && b_vld) begin
          phase_p2 <= cur_ph;
          init_p2  <= 1'b0;
        end
      end else if (cur_ph != phase_p2) begin
        phase_p2 <= cur_ph;
        if (cur_ph == phase_fwd(phase_p2)) begin
          up_down <= UP;
          if (en) begin
            count <= count + CNT_W'(1);
            step  <= 1'b1;
          end
        end else if (cur_ph == phase_rev(phase_p2)) begin
          up_down <= DOWN;
          if (en) begin
            count <= count - CNT_W'(1);
            step  <= 1'b1;
          end
        end else begin
          err      <= 1'b1;
          err_flag <= 1'b1;
        end
      end
      // clr overrides any count/flag update from this same cycle.
      if (clr) begin
        count    <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
`timescale 1ns/1ps
module tb_quad_decoder;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 3;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             en = 1'b1;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] count;
  logic             up_down;
  logic             step;
  logic             err;
  logic             err_flag;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int err_cnt = 0;

  quad_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .en       (en),
    .clr      (clr),
    .count    (count),
    .up_down  (up_down),
    .step     (step),
    .err      (err),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (step) step_cnt++;
    if (err)  err_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic a;
    logic b;
    logic en;
    logic clr;
    int   exp_count;
    int   exp_ud;
    int   exp_ef;
    int   exp_steps;
    int   exp_errs;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Quadrant index along the up direction: 00=0, 01=1, 11=2, 10=3.
  function automatic logic [1:0] ab_of(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int idx_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  int idx;
  int s0, e0;
  int lat;
  int m_count, m_ud, m_ef, m_steps, m_errs, delta, r, len;
  logic [1:0] ab_r;

  initial begin
    // stimulus table: each row holds for 10 cycles
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0,   1, 1, 0, 1, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0,   2, 1, 0, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0,   3, 1, 0, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0,   4, 1, 0, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1,   0, 1, 0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 255, 0, 0, 1, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 254, 0, 0, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 253, 0, 0, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 252, 0, 0, 1, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 252, 0, 1, 0, 1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1,   0, 0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0,   0, 1, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0,   0, 1, 1, 0, 1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1,   0, 1, 0, 0, 0};

    // reset with ab=00
    rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (3) tick();
    check("reset count", int'(count), 0);
    check("reset up_down", int'(up_down), 0);
    check("reset step", int'(step), 0);
    check("reset err", int'(err), 0);
    check("reset err_flag", int'(err_flag), 0);
    rst = 1'b0;
    repeat (12) tick();

    // table-driven sequence
    for (int i = 0; i < 14; i++) begin
      s0 = step_cnt; e0 = err_cnt;
      a = vecs[i].a; b = vecs[i].b; en = vecs[i].en; clr = vecs[i].clr;
      tick();
      clr = 1'b0;
      repeat (9) tick();
      check($sformatf("row%0d count", i), int'(count), vecs[i].exp_count);
      check($sformatf("row%0d up_down", i), int'(up_down), vecs[i].exp_ud);
      check($sformatf("row%0d err_flag", i), int'(err_flag), vecs[i].exp_ef);
      check($sformatf("row%0d steps", i), step_cnt - s0, vecs[i].exp_steps);
      check($sformatf("row%0d errs", i), err_cnt - e0, vecs[i].exp_errs);
    end

    // input-to-step latency: ab 01 -> 11
    en = 1'b1;
    lat = -1;
    a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (step && lat < 0) lat = i;
    end
    check("latency", lat, SYNC_STAGES + FILT_LEN + 1);
    check("latency count", int'(count), 1);

    // 2-cycle glitch on a while ab=11
    s0 = step_cnt; e0 = err_cnt;
    a = 1'b0;
    tick(); tick();
    a = 1'b1;
    repeat (12) tick();
    check("glitch steps", step_cnt - s0, 0);
    check("glitch errs", err_cnt - e0, 0);
    check("glitch count", int'(count), 1);

    // reset released with ab=11
    rst = 1'b1; a = 1'b1; b = 1'b1;
    repeat (3) tick();
    check("rst11 count", int'(count), 0);
    check("rst11 up_down", int'(up_down), 0);
    rst = 1'b0;
    s0 = step_cnt; e0 = err_cnt;
    repeat (15) tick();
    check("rst11 steps", step_cnt - s0, 0);
    check("rst11 errs", err_cnt - e0, 0);
    check("rst11 err_flag", int'(err_flag), 0);

    // valid step with en=0: 11 -> 10
    en = 1'b0;
    s0 = step_cnt;
    a = 1'b1; b = 1'b0;
    repeat (10) tick();
    check("en0 count", int'(count), 0);
    check("en0 up_down", int'(up_down), 1);
    check("en0 steps", step_cnt - s0, 0);
    en = 1'b1;

    // preload 255 with up steps, then wrap to 0
    idx = 3;
    s0 = step_cnt;
    for (int i = 0; i < 255; i++) begin
      idx = (idx + 1) & 3;
      {a, b} = ab_of(idx);
      repeat (8) tick();
    end
    check("preload count", int'(count), 255);
    check("preload steps", step_cnt - s0, 255);
    idx = (idx + 1) & 3;
    {a, b} = ab_of(idx);
    repeat (10) tick();
    check("wrap count", int'(count), 0);
    check("wrap up_down", int'(up_down), 1);

    // set err_flag and a non-zero count, then reset with a step in flight
    idx = (idx + 2) & 3;
    {a, b} = ab_of(idx);
    repeat (10) tick();
    check("jump err_flag", int'(err_flag), 1);
    idx = (idx + 1) & 3;
    {a, b} = ab_of(idx);
    repeat (10) tick();
    check("pre-rst count", int'(count), 1);
    idx = (idx + 1) & 3;
    {a, b} = ab_of(idx);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst count", int'(count), 0);
    check("midrst up_down", int'(up_down), 0);
    check("midrst step", int'(step), 0);
    check("midrst err", int'(err), 0);
    check("midrst err_flag", int'(err_flag), 0);
    rst = 1'b0;
    s0 = step_cnt; e0 = err_cnt;
    repeat (15) tick();
    check("midrst discard steps", step_cnt - s0, 0);
    check("midrst discard errs", err_cnt - e0, 0);

    // randomized actions against a quadrant-index position model
    rst = 1'b1;
    ab_r = 2'($urandom_range(0, 3));
    {a, b} = ab_r;
    idx = idx_of(ab_r);
    tick(); tick();
    rst = 1'b0;
    repeat (12) tick();
    m_count = 0; m_ud = 0; m_ef = 0;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      en = ($urandom_range(0, 3) != 0);
      s0 = step_cnt; e0 = err_cnt;
      m_steps = 0; m_errs = 0;
      if (r <= 6) begin
        delta = (r <= 5) ? (((r % 2) == 0) ? 1 : 3) : 2;
        idx = (idx + delta) & 3;
        if (delta == 1) begin
          m_ud = 1;
          if (en) begin m_count = (m_count + 1) % CNT_MOD; m_steps = 1; end
        end else if (delta == 3) begin
          m_ud = 0;
          if (en) begin m_count = (m_count + CNT_MOD - 1) % CNT_MOD; m_steps = 1; end
        end else begin
          m_ef = 1; m_errs = 1;
        end
        {a, b} = ab_of(idx);
        repeat (12) tick();
      end else if (r == 7) begin
        len = $urandom_range(1, FILT_LEN - 1);
        if ($urandom_range(0, 1) == 0) a = ~a; else b = ~b;
        repeat (len) tick();
        {a, b} = ab_of(idx);
        repeat (12) tick();
      end else begin
        m_count = 0; m_ef = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (11) tick();
      end
      check($sformatf("rand%0d count", it), int'(count), m_count);
      check($sformatf("rand%0d up_down", it), int'(up_down), m_ud);
      check($sformatf("rand%0d err_flag", it), int'(err_flag), m_ef);
      check($sformatf("rand%0d steps", it), step_cnt - s0, m_steps);
      check($sformatf("rand%0d errs", it), err_cnt - e0, m_errs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
